// File: rtl/knes_dma_pkg.sv
// Shared definitions for the knes DMA controllers: state encoding, bus addresses
// and transfer lengths used by both the RTL and the bench.
package knes_dma_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      GET   = 3'd3,
      PUT   = 3'd4
   } oam_dma_state_t;

   localparam logic [15:0] OAM_DMA_TRIG_ADDR = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR      = 16'h2004;

   // Stall lengths when the CPU reads in the cycle right after the trigger
   localparam int OAM_DMA_CYCLES       = 513;
   localparam int OAM_DMA_CYCLES_ALIGN = 514;

   function automatic logic [15:0] dma_src_addr(input logic [7:0] page, input logic [7:0] idx);
      return {page, idx};
   endfunction

endpackage

// File: rtl/oam_dma_ctl_if.sv
// CPU-side and DMA-side bus signals of the OAM DMA controller.
// slave: the controller; master: whatever drives the CPU bus and memory.
interface oam_dma_ctl_if;

   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic        cpu_rw;
   logic [7:0]  bus_d_in;
   logic        rdy;
   logic        dma_own;
   logic [15:0] dma_a;
   logic [7:0]  dma_d;
   logic        dma_rw;
   logic        busy;

   modport slave (
      input  cpu_a, cpu_d, cpu_rw, bus_d_in,
      output rdy, dma_own, dma_a, dma_d, dma_rw, busy
   );

   modport master (
      output cpu_a, cpu_d, cpu_rw, bus_d_in,
      input  rdy, dma_own, dma_a, dma_d, dma_rw, busy
   );

endinterface

// File: rtl/cpu_cycle_parity.sv
// Free-running get/put phase flop; cleared by reset so the first cycle after
// reset is a get cycle (put_phase = 0).
module cpu_cycle_parity (
   input  logic clk,
   input  logic reset,
   output logic put_phase
);

   // Toggle every CPU cycle, never stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         put_phase <= 1'b0;
      end else begin
         put_phase <= ~put_phase;
      end
   end

endmodule

// File: rtl/oam_dma_ctl.sv
// OAM DMA controller: a write to $4014 halts the CPU, then copies $XX00-$XXFF to OAMDATA.
// Define KNES_OAM_DMA_ALIGN_EN for the cycle-accurate get/put alignment (ALIGN state).
module oam_dma_ctl
   import knes_dma_pkg::*;
#(
   parameter logic [15:0] OAM_PORT_ADDR = OAMDATA_ADDR,
   parameter logic [15:0] DMA_TRIG_ADDR = OAM_DMA_TRIG_ADDR
) (
   input logic          ph0,
   input logic          reset,
   oam_dma_ctl_if.slave bus
);

   oam_dma_state_t state, state_next;
   logic [7:0]     page, page_next;
   logic [7:0]     idx, idx_next;
   logic           trig;
   logic           exit_to_get;

`ifdef KNES_OAM_DMA_ALIGN_EN
   logic put_phase;

   cpu_cycle_parity u_parity (
      .clk       (ph0),
      .reset     (reset),
      .put_phase (put_phase)
   );

   // A dummy cycle on a put phase is followed by a get phase
   assign exit_to_get = put_phase;
`else
   assign exit_to_get = 1'b1;
`endif

   assign trig = (bus.cpu_a == DMA_TRIG_ADDR) && !bus.cpu_rw && !bus.dma_own;

   // Next-state, page and index decode
   always_comb begin
      state_next = state;
      page_next  = page;
      idx_next   = idx;
      case (state)
         IDLE: begin
            if (trig) begin
               page_next  = bus.cpu_d;
               idx_next   = 8'h00;
               state_next = HALT;
            end else begin
               state_next = IDLE;
            end
         end
         HALT: begin
            if (bus.cpu_rw) begin
               state_next = exit_to_get ? GET : ALIGN;
            end else begin
               state_next = HALT;
            end
         end
         ALIGN: state_next = GET;
         GET:   state_next = PUT;
         PUT: begin
            idx_next = idx + 8'd1;
            if (idx == 8'hFF) begin
               state_next = IDLE;
            end else begin
               state_next = GET;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State plus outputs registered from the next state, so nothing is combinational from cpu_*
   always_ff @(posedge ph0) begin
      if (reset) begin
         state       <= IDLE;
         page        <= 8'h00;
         idx         <= 8'h00;
         bus.rdy     <= 1'b1;
         bus.dma_own <= 1'b0;
         bus.dma_rw  <= 1'b1;
         bus.dma_a   <= 16'h0000;
         bus.dma_d   <= 8'h00;
         bus.busy    <= 1'b0;
      end else begin
         state       <= state_next;
         page        <= page_next;
         idx         <= idx_next;
         bus.rdy     <= (state_next == IDLE);
         bus.busy    <= (state_next != IDLE);
         bus.dma_own <= (state_next == GET) || (state_next == PUT);
         bus.dma_rw  <= (state_next != PUT);
         if (state_next == GET) begin
            bus.dma_a <= dma_src_addr(page_next, idx_next);
         end else if (state_next == PUT) begin
            bus.dma_a <= OAM_PORT_ADDR;
         end else begin
            bus.dma_a <= 16'h0000;
         end
         // dma_d doubles as the get-data latch: sampled at the end of GET, held through PUT
         if (state_next == PUT) begin
            bus.dma_d <= bus.bus_d_in;
         end else begin
            bus.dma_d <= 8'h00;
         end
      end
   end

endmodule
